// File: rtl/s2_seq_cell_pkg.sv
// Shared select encodings and select decode for the fabric mux cells.
package s2_seq_cell_pkg;

  localparam logic [1:0] SEL_D0 = 2'd0;
  localparam logic [1:0] SEL_D1 = 2'd1;
  localparam logic [1:0] SEL_D2 = 2'd2;
  localparam logic [1:0] SEL_D3 = 2'd3;

  // High select is the AND pair and low select is the OR pair.
  function automatic logic [1:0] sel_decode(input logic a1, input logic b1,
                                            input logic a0, input logic b0);
    return {a1 & b1, a0 | b0};
  endfunction

endpackage

// File: rtl/s2_seq_cell_mux.sv
// Combinational 4:1 fabric mux with AND/OR select decode. The combinational
// fabric cell uses the same module.
module s2_mux
  import s2_seq_cell_pkg::*;
(
  input  logic [3:0] d,
  input  logic       A1,
  input  logic       B1,
  input  logic       A0,
  input  logic       B0,
  output logic       m
);

  logic [1:0] sel;

  assign sel = sel_decode(A1, B1, A0, B0);

  // Select only the chosen bit so that an unknown value on an unselected input
  // cannot reach m.
  always_comb begin
    m = 1'b0;
    case (sel)
      SEL_D0:  m = d[0];
      SEL_D1:  m = d[1];
      SEL_D2:  m = d[2];
      SEL_D3:  m = d[3];
      default: m = 1'b0;
    endcase
  end

endmodule

// File: rtl/s2_seq_cell.sv
// Registered fabric cell: s2_mux followed by a D flip-flop with a synchronous,
// active-low clear.
module s2_seq_cell (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d,
  input  logic       A1,
  input  logic       B1,
  input  logic       A0,
  input  logic       B0,
  output logic       out
);

  logic m;

  s2_mux u_mux (
    .d  (d),
    .A1 (A1),
    .B1 (B1),
    .A0 (A0),
    .B0 (B0),
    .m  (m)
  );

  always_ff @(posedge clk) begin
    if (!clr) out <= 1'b0;
    else      out <= m;
  end

endmodule

// File: tb/tb_s2_seq_cell.sv
// Directed and exhaustive bench for s2_seq_cell, using a queue of expected outputs.
module tb_s2_seq_cell;

  logic       clk;
  logic       clr;
  logic [3:0] d;
  logic       A1, B1, A0, B0;
  logic       out;

  int checks = 0;
  int passed = 0;
  logic exp_q[$];

  s2_seq_cell dut (
    .clk (clk),
    .clr (clr),
    .d   (d),
    .A1  (A1),
    .B1  (B1),
    .A0  (A0),
    .B0  (B0),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model(input logic c, input logic [3:0] dv,
                                 input logic a1, input logic b1,
                                 input logic a0, input logic b0);
    logic [1:0] idx;
    idx = {a1 & b1, a0 | b0};
    return c ? dv[idx] : 1'b0;
  endfunction

  task automatic check_pop(input string tag);
    logic e;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: queue empty, observed %b", tag, out);
    end else begin
      e = exp_q.pop_front();
      assert (out === e) begin
        passed++;
      end else begin
        $error("FAIL %s: observed %b expected %b", tag, out, e);
      end
    end
  endtask

  task automatic step(input logic c, input logic [3:0] dv,
                      input logic a1, input logic b1,
                      input logic a0, input logic b0,
                      input logic e, input string tag);
    @(negedge clk);
    clr = c; d = dv; A1 = a1; B1 = b1; A0 = a0; B0 = b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    logic [7:0] v;
    clr = 1'b1; d = 4'b0; A1 = 0; B1 = 0; A0 = 0; B0 = 0;

    step(0, 4'b0110, 1, 1, 1, 1, 1'b0, "reset");
    step(1, 4'b1111, 1, 1, 1, 1, 1'b1, "sel3_all_ones");
    step(1, 4'b0110, 1, 1, 1, 0, 1'b0, "or_low_d3_0");
    step(1, 4'b1000, 1, 1, 1, 0, 1'b1, "or_low_d3_1");
    step(1, 4'b0110, 0, 0, 1, 1, 1'b1, "and_hi_d1");
    step(1, 4'b0110, 1, 0, 1, 1, 1'b1, "and_hi_partial");
    step(1, 4'b0110, 1, 0, 0, 0, 1'b0, "and_hi_d0");
    step(1, 4'b0100, 1, 0, 0, 1, 1'b0, "or_low_b0_d1");
    step(1, 4'b0100, 1, 1, 0, 0, 1'b1, "sel2_d2");
    step(0, 4'b1111, 0, 0, 0, 0, 1'b0, "clr_priority");

    // Unknown value on unselected inputs must not reach out.
    step(1, 4'bxx1x, 0, 0, 1, 0, 1'b1, "x_unselected");

    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      step(1, v[3:0], v[6], v[7], v[4], v[5],
           model(1'b1, v[3:0], v[6], v[7], v[4], v[5]), "exhaustive");
    end

    // Dropping clr between edges must leave out unchanged until the next edge.
    step(1, 4'b0001, 0, 0, 0, 0, 1'b1, "pre_clear_one");
    @(negedge clk);
    clr = 1'b0;
    #2;
    exp_q.push_back(1'b1);
    check_pop("clr_hold_between_edges");
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    check_pop("clr_at_edge");
    @(negedge clk);
    clr = 1'b1;
    #2;
    exp_q.push_back(1'b0);
    check_pop("release_hold_between_edges");
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    check_pop("release_loads_m");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
